// File: rtl/queue_reducer.sv
// Purpose: pops a programmable-length group of words from the word queue and reduces them to sum/min/max.
// Latency: start accepted at E0, words accepted at E1..EN, result valid the cycle after EN.
// Backpressure: the result is held in OUTPUT until out_ready, with no pops meanwhile.
// Build option: define QUEUE_REDUCER_SAT_EN to saturate out_sum on overflow (default wraps).
module queue_reducer #(
    parameter int DATA_WIDTH = 16,
    parameter int SUM_WIDTH  = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [7:0]            group_len,
    input  logic                  q_empty,
    input  logic [DATA_WIDTH-1:0] q_data,
    output logic                  q_deq_ready,
    output logic                  busy,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SUM_WIDTH-1:0]  out_sum,
    output logic [DATA_WIDTH-1:0] out_min,
    output logic [DATA_WIDTH-1:0] out_max,
    output logic                  out_ovf
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_OUTPUT  = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [8:0]             remaining;
    logic                   first_word;
    logic                   accept;
    logic                   start_acc;
    logic [SUM_WIDTH-1:0]   data_ext;
    logic [SUM_WIDTH:0]     sum_wide;
    logic [SUM_WIDTH-1:0]   sum_nxt;

    // A word is taken whenever we are collecting and the queue head is valid.
    assign accept    = (state == S_COLLECT) && !q_empty;
    assign start_acc = (state == S_IDLE) && start;

    // Unsigned head word widened to the accumulator width; the extra bit captures the carry.
    assign data_ext = SUM_WIDTH'(q_data);
    assign sum_wide = {1'b0, out_sum} + {1'b0, data_ext};

`ifdef QUEUE_REDUCER_SAT_EN
    // Once pinned at all-ones, any further add either carries or adds zero, so it stays pinned.
    assign sum_nxt = sum_wide[SUM_WIDTH] ? {SUM_WIDTH{1'b1}} : sum_wide[SUM_WIDTH-1:0];
`else
    // Modulo arithmetic: drop the carry.
    assign sum_nxt = sum_wide[SUM_WIDTH-1:0];
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; the last accepted word of the group moves straight to OUTPUT.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start) state_nxt = S_COLLECT;
            S_COLLECT: if (accept && (remaining == 9'd1)) state_nxt = S_OUTPUT;
            S_OUTPUT:  if (out_ready) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Control outputs decoded purely from the state register (no input-to-output paths).
    always_comb begin
        q_deq_ready = 1'b0;
        busy        = 1'b0;
        out_valid   = 1'b0;
        case (state)
            S_COLLECT: begin
                q_deq_ready = 1'b1;
                busy        = 1'b1;
            end
            S_OUTPUT: begin
                out_valid   = 1'b1;
                busy        = 1'b1;
            end
            default: begin
                q_deq_ready = 1'b0;
                busy        = 1'b0;
                out_valid   = 1'b0;
            end
        endcase
    end

    // Group datapath: clear on start, fold each accepted word into sum/min/max, count down.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining  <= 9'd0;
            first_word <= 1'b0;
            out_sum    <= '0;
            out_min    <= '0;
            out_max    <= '0;
            out_ovf    <= 1'b0;
        end else if (start_acc) begin
            remaining  <= (group_len == 8'd0) ? 9'd256 : {1'b0, group_len};
            first_word <= 1'b1;
            out_sum    <= '0;
            out_min    <= '0;
            out_max    <= '0;
            out_ovf    <= 1'b0;
        end else if (accept) begin
            remaining  <= remaining - 9'd1;
            first_word <= 1'b0;
            out_sum    <= sum_nxt;
            out_ovf    <= out_ovf | sum_wide[SUM_WIDTH];
            if (first_word || (q_data < out_min)) begin
                out_min <= q_data;
            end
            if (first_word || (q_data > out_max)) begin
                out_max <= q_data;
            end
        end
    end

endmodule

// File: tb/tb_queue_reducer.sv
// Scoreboard bench for queue_reducer: directed groups pushed through a software word queue,
// expected records queued at stimulus time and compared by a separate monitor on handshake.
// The accumulator is built 16 bits wide so the overflow case is reachable.
module tb_queue_reducer;

    localparam int DW = 16;
    localparam int SW = 16;

    typedef struct {
        logic [SW-1:0] sum;
        logic [DW-1:0] mn;
        logic [DW-1:0] mx;
        logic          ovf;
    } rec_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [7:0]    group_len;
    logic          q_empty;
    logic [DW-1:0] q_data;
    logic          q_deq_ready;
    logic          busy;
    logic          out_valid;
    logic          out_ready;
    logic [SW-1:0] out_sum;
    logic [DW-1:0] out_min;
    logic [DW-1:0] out_max;
    logic          out_ovf;

    logic [DW-1:0] fifo[$];
    rec_t          exp_q[$];
    int            checks;
    int            failures;
    int            pops;
    int            valid_cnt;
    logic          pop_now;

    queue_reducer #(.DATA_WIDTH(DW), .SUM_WIDTH(SW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .group_len  (group_len),
        .q_empty    (q_empty),
        .q_data     (q_data),
        .q_deq_ready(q_deq_ready),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_min    (out_min),
        .out_max    (out_max),
        .out_ovf    (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Present the head of the model queue to the DUT.
    task automatic refresh();
        q_empty = (fifo.size() == 0);
        q_data  = q_empty ? '0 : fifo[0];
    endtask

    task automatic push(input logic [DW-1:0] w);
        fifo.push_back(w);
        refresh();
    endtask

    // Advance one clock; the pop decision uses pre-edge values, the queue advances #1 later.
    task automatic tick();
        @(posedge clk);
        pop_now = q_deq_ready && !q_empty && rst_n;
        #1;
        if (pop_now) begin
            void'(fifo.pop_front());
            pops++;
        end
        refresh();
    endtask

    task automatic expect_rec(input logic [SW-1:0] s, input logic [DW-1:0] mn,
                              input logic [DW-1:0] mx, input logic ovf);
        rec_t r;
        r.sum = s;
        r.mn  = mn;
        r.mx  = mx;
        r.ovf = ovf;
        exp_q.push_back(r);
    endtask

    task automatic start_group(input logic [7:0] len);
        start     = 1'b1;
        group_len = len;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!busy) break;
            tick();
        end
        chk(name, busy, 1'b0);
    endtask

    // Monitor: counts valid cycles and checks a record whenever a handshake will occur.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            valid_cnt++;
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_record sum=%0h required=none", out_sum);
                end else begin
                    rec_t r;
                    r = exp_q.pop_front();
                    chk("rec_sum", out_sum, r.sum);
                    chk("rec_min", out_min, r.mn);
                    chk("rec_max", out_max, r.mx);
                    chk("rec_ovf", out_ovf, r.ovf);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int v0;
        checks    = 0;
        failures  = 0;
        pops      = 0;
        valid_cnt = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        group_len = 8'd0;
        out_ready = 1'b1;
        refresh();

        // Reset values.
        #2;
        chk("rst_deq_ready", q_deq_ready, 0);
        chk("rst_busy",      busy,        0);
        chk("rst_out_valid", out_valid,   0);
        chk("rst_sum",       out_sum,     0);
        chk("rst_min",       out_min,     0);
        chk("rst_max",       out_max,     0);
        chk("rst_ovf",       out_ovf,     0);
        #10;
        rst_n = 1'b1;
        tick();

        // Basic group: 1,2,3,4 popped on four consecutive edges, one valid cycle.
        push(16'd1); push(16'd2); push(16'd3); push(16'd4);
        expect_rec(16'd10, 16'd1, 16'd4, 1'b0);
        p0 = pops;
        v0 = valid_cnt;
        start_group(8'd4);
        chk("basic_busy_after_start", busy, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("basic_consecutive_pops", pops - p0, i + 1);
        end
        chk("basic_valid_after_last", out_valid, 1);
        wait_idle("basic_idle", 5);
        tick();
        chk("basic_valid_cycles", valid_cnt - v0, 1);

        // Starved queue: 7, 2, 9 arriving with gaps.
        expect_rec(16'd18, 16'd2, 16'd9, 1'b0);
        start_group(8'd3);
        push(16'd7);
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("starve_deq_ready", q_deq_ready, 1);
            chk("starve_sum_hold",  out_sum, 16'd7);
        end
        push(16'd2);
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("starve_min_hold", out_min, 16'd2);
        end
        push(16'd9);
        wait_idle("starve_idle", 10);

        // Backpressure: 5,6 held in OUTPUT for 10 cycles; starts and a queued word ignored.
        push(16'd5); push(16'd6); push(16'd99);
        expect_rec(16'd11, 16'd5, 16'd6, 1'b0);
        out_ready = 1'b0;
        start_group(8'd2);
        for (int i = 0; i < 10; i++) begin
            if (out_valid) break;
            tick();
        end
        chk("bp_valid_reached", out_valid, 1);
        p0 = pops;
        for (int i = 0; i < 10; i++) begin
            start     = (i % 3 == 0);
            group_len = 8'd1;
            tick();
            chk("bp_valid_hold", out_valid,   1);
            chk("bp_sum_hold",   out_sum,     16'd11);
            chk("bp_minmax",     {out_min, out_max}, {16'd5, 16'd6});
            chk("bp_no_deq",     q_deq_ready, 0);
        end
        chk("bp_no_pops", pops - p0, 0);
        start     = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_idle_next", busy, 0);
        chk("bp_valid_drop", out_valid, 0);
        chk("bp_result_kept", out_sum, 16'd11);

        // Single-word group: the 99 left in the queue.
        expect_rec(16'd99, 16'd99, 16'd99, 1'b0);
        start_group(8'd1);
        wait_idle("len1_idle", 5);

        // Overflow in a 16-bit accumulator.
`ifdef QUEUE_REDUCER_SAT_EN
        expect_rec(16'hFFFF, 16'h0002, 16'hFFFF, 1'b1);
`else
        expect_rec(16'h0001, 16'h0002, 16'hFFFF, 1'b1);
`endif
        push(16'hFFFF); push(16'h0002);
        start_group(8'd2);
        wait_idle("ovf_idle", 6);

        // Reset mid-group: abort after 2 of 4 pops, then a fresh 2-word group takes 30,40.
        push(16'd10); push(16'd20); push(16'd30); push(16'd40);
        p0 = pops;
        start_group(8'd4);
        for (int i = 0; i < 10; i++) begin
            if (pops - p0 >= 2) break;
            tick();
        end
        chk("mid_pops_before_rst", pops - p0, 2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy",      busy,        0);
        chk("mid_rst_deq_ready", q_deq_ready, 0);
        chk("mid_rst_valid",     out_valid,   0);
        chk("mid_rst_sum",       out_sum,     0);
        chk("mid_rst_minmax",    {out_min, out_max}, 32'd0);
        chk("mid_rst_ovf",       out_ovf,     0);
        #2;
        rst_n = 1'b1;
        tick();
        expect_rec(16'd70, 16'd30, 16'd40, 1'b0);
        start_group(8'd2);
        wait_idle("mid_fresh_idle", 6);

        // Length 0 means 256 words.
        for (int i = 0; i < 256; i++) push(16'd1);
        expect_rec(16'd256, 16'd1, 16'd1, 1'b0);
        p0 = pops;
        start_group(8'd0);
        wait_idle("len0_idle", 300);
        chk("len0_pops", pops - p0, 256);
        chk("len0_queue_drained", fifo.size(), 0);

        tick();
        tick();
        chk("all_records_seen", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
